dram_refresh_arbiter: RTL and testbench



---
 rtl/dram_ctrl_pkg.sv | 20 ++
 rtl/dram_refresh_timer.sv | 56 +++++
 rtl/dram_refresh_arbiter.sv | 141 ++++++++++++++
 tb/tb_dram_refresh_arbiter.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/dram_ctrl_pkg.sv
// Shared command encodings, arbiter state type and debt width for the DRAM refresh arbiter.
// Optional feature macro: DRAM_REFRESH_POSTPONE_EN (consumed by dram_refresh_arbiter).
package dram_ctrl_pkg;

  localparam logic [1:0] CMD_NOP     = 2'b00;
  localparam logic [1:0] CMD_READ    = 2'b01;
  localparam logic [1:0] CMD_WRITE   = 2'b10;
  localparam logic [1:0] CMD_REFRESH = 2'b11;

  localparam int DEBT_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACC_REQ,
    ST_REF_REQ,
    ST_ACK_LOW,
    ST_RFC
  } state_e;

endpackage

// File: rtl/dram_refresh_timer.sv
// Refresh interval timer plus postponed-refresh debt counter with sticky overflow flag.
// The debt ceiling comes in as 'limit' so the top can choose it (see DRAM_REFRESH_POSTPONE_EN).
module dram_refresh_timer
  import dram_ctrl_pkg::*;
#(
  parameter int REFRESH_INTERVAL = 780
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dec,
  input  logic [DEBT_W-1:0] limit,
  output logic [DEBT_W-1:0] refresh_debt,
  output logic              urgent,
  output logic              debt_overflow
);

  localparam int CNT_W = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DEBT_W-1:0] debt_q, debt_d;
  logic              ovf_q, ovf_d;
  logic              tick;
  logic              at_limit;

  assign tick     = (cnt_q == CNT_W'(REFRESH_INTERVAL - 1));
  assign at_limit = (debt_q == limit);

  // A tick and a refresh retirement in the same cycle cancel out.
  always_comb begin
    cnt_d  = tick ? '0 : cnt_q + CNT_W'(1);
    debt_d = debt_q;
    ovf_d  = ovf_q | (tick & at_limit);
    if (tick && !dec && !at_limit) begin
      debt_d = debt_q + DEBT_W'(1);
    end else if (dec && !tick && (debt_q != '0)) begin
      debt_d = debt_q - DEBT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      debt_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      debt_q <= debt_d;
      ovf_q  <= ovf_d;
    end
  end

  assign refresh_debt  = debt_q;
  assign urgent        = at_limit;
  assign debt_overflow = ovf_q;

endmodule

// File: rtl/dram_refresh_arbiter.sv
// Shares the DRAM command channel between accesses and refresh using a four-phase req/ack handshake.
// Build option DRAM_REFRESH_POSTPONE_EN: allow refresh debt up to MAX_POSTPONE; otherwise the limit is 1.
module dram_refresh_arbiter
  import dram_ctrl_pkg::*;
#(
  parameter int NUM_OF_BANKS     = 8,
  parameter int REFRESH_INTERVAL = 780,
  parameter int MAX_POSTPONE     = 8,
  parameter int TRFC             = 16,
  localparam int BANK_ID_W       = $clog2(NUM_OF_BANKS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 acc_valid,
  input  logic                 acc_rw,
  input  logic [BANK_ID_W-1:0] acc_bank_id,
  output logic                 acc_ready,
  output logic                 cmd_req,
  output logic [1:0]           cmd,
  output logic [BANK_ID_W-1:0] cmd_bank_id,
  input  logic                 cmd_ack,
  output logic                 refresh_flag,
  output logic [3:0]           refresh_debt,
  output logic                 debt_overflow
);

`ifdef DRAM_REFRESH_POSTPONE_EN
  localparam logic [DEBT_W-1:0] LIMIT = DEBT_W'(MAX_POSTPONE);
`else
  localparam logic [DEBT_W-1:0] LIMIT = DEBT_W'(1);
`endif

  localparam int RFC_W = $clog2(TRFC + 1);

  state_e               state_q, state_d;
  logic                 cmd_req_q, cmd_req_d;
  logic [1:0]           cmd_q, cmd_d;
  logic [BANK_ID_W-1:0] bank_q, bank_d;
  logic                 flag_q, flag_d;
  logic                 is_ref_q, is_ref_d;
  logic [RFC_W-1:0]     rfc_q, rfc_d;
  logic                 dec;
  logic                 urgent;
  logic [DEBT_W-1:0]    debt;

  dram_refresh_timer #(
    .REFRESH_INTERVAL(REFRESH_INTERVAL)
  ) u_timer (
    .clk          (clk),
    .rst          (rst),
    .dec          (dec),
    .limit        (LIMIT),
    .refresh_debt (debt),
    .urgent       (urgent),
    .debt_overflow(debt_overflow)
  );

  always_comb begin
    state_d   = state_q;
    cmd_req_d = cmd_req_q;
    cmd_d     = cmd_q;
    bank_d    = bank_q;
    flag_d    = flag_q;
    is_ref_d  = is_ref_q;
    rfc_d     = rfc_q;
    dec       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Refresh goes first when urgent, or opportunistically when no access is waiting.
        if (urgent || (!acc_valid && (debt != '0))) begin
          state_d   = ST_REF_REQ;
          cmd_req_d = 1'b1;
          cmd_d     = CMD_REFRESH;
          bank_d    = '0;
          flag_d    = 1'b1;
          is_ref_d  = 1'b1;
        end else if (acc_valid) begin
          state_d   = ST_ACC_REQ;
          cmd_req_d = 1'b1;
          cmd_d     = acc_rw ? CMD_WRITE : CMD_READ;
          bank_d    = acc_bank_id;
          is_ref_d  = 1'b0;
        end
      end
      ST_ACC_REQ, ST_REF_REQ: begin
        if (cmd_ack) begin
          state_d   = ST_ACK_LOW;
          cmd_req_d = 1'b0;
          dec       = is_ref_q;
        end
      end
      ST_ACK_LOW: begin
        if (!cmd_ack) begin
          if (is_ref_q) begin
            state_d = ST_RFC;
            rfc_d   = RFC_W'(TRFC - 1);
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_RFC: begin
        if (rfc_q == '0) begin
          state_d = ST_IDLE;
          flag_d  = 1'b0;
        end else begin
          rfc_d = rfc_q - RFC_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cmd_req_q <= 1'b0;
      cmd_q     <= CMD_NOP;
      bank_q    <= '0;
      flag_q    <= 1'b0;
      is_ref_q  <= 1'b0;
      rfc_q     <= '0;
    end else begin
      state_q   <= state_d;
      cmd_req_q <= cmd_req_d;
      cmd_q     <= cmd_d;
      bank_q    <= bank_d;
      flag_q    <= flag_d;
      is_ref_q  <= is_ref_d;
      rfc_q     <= rfc_d;
    end
  end

  assign acc_ready    = (state_q == ST_IDLE) && !urgent;
  assign cmd_req      = cmd_req_q;
  assign cmd          = cmd_q;
  assign cmd_bank_id  = bank_q;
  assign refresh_flag = flag_q;
  assign refresh_debt = debt;

endmodule

// File: tb/tb_dram_refresh_arbiter.sv
// Randomized bench for dram_refresh_arbiter against a transaction-level reference model.
// Honours DRAM_REFRESH_POSTPONE_EN to pick the expected debt ceiling.
module tb_dram_refresh_arbiter;

  localparam int RI   = 20;
  localparam int MP   = 2;
  localparam int TRFC = 4;
  localparam int NB   = 8;
  localparam int BW   = 3;
`ifdef DRAM_REFRESH_POSTPONE_EN
  localparam int LIM = MP;
`else
  localparam int LIM = 1;
`endif

  logic          clk;
  logic          rst;
  logic          acc_valid;
  logic          acc_rw;
  logic [BW-1:0] acc_bank_id;
  logic          acc_ready;
  logic          cmd_req;
  logic [1:0]    cmd;
  logic [BW-1:0] cmd_bank_id;
  logic          cmd_ack;
  logic          refresh_flag;
  logic [3:0]    refresh_debt;
  logic          debt_overflow;
  logic          ack_block;
  logic          ack_d1;

  dram_refresh_arbiter #(
    .NUM_OF_BANKS    (NB),
    .REFRESH_INTERVAL(RI),
    .MAX_POSTPONE    (MP),
    .TRFC            (TRFC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .acc_valid    (acc_valid),
    .acc_rw       (acc_rw),
    .acc_bank_id  (acc_bank_id),
    .acc_ready    (acc_ready),
    .cmd_req      (cmd_req),
    .cmd          (cmd),
    .cmd_bank_id  (cmd_bank_id),
    .cmd_ack      (cmd_ack),
    .refresh_flag (refresh_flag),
    .refresh_debt (refresh_debt),
    .debt_overflow(debt_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Responder: ack follows req with a two-cycle lag; ack_block pins it low.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_d1  <= 1'b0;
      cmd_ack <= 1'b0;
    end else begin
      ack_d1  <= cmd_req;
      cmd_ack <= ack_block ? 1'b0 : ack_d1;
    end
  end

  // Reference model: command in flight, waiting for ack release, recovery cycles left.
  int m_cyc, m_debt, m_cmd, m_bank, m_rfc_left;
  bit m_ovf, m_req, m_wait_low, m_is_ref;

  int checks = 0;
  int errors = 0;
  int txns = 0;
  int coincide = 0;

  task automatic check_val(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_idle();
    return !m_req && !m_wait_low && (m_rfc_left == 0);
  endfunction

  task automatic model_reset();
    m_cyc = 0; m_debt = 0; m_cmd = 0; m_bank = 0; m_rfc_left = 0;
    m_ovf = 0; m_req = 0; m_wait_low = 0; m_is_ref = 0;
  endtask

  task automatic compare_outputs();
    check_val("cmd_req", cmd_req, m_req);
    check_val("cmd", cmd, m_cmd);
    check_val("cmd_bank_id", cmd_bank_id, m_bank);
    check_val("refresh_flag", refresh_flag, m_is_ref && !m_idle());
    check_val("refresh_debt", refresh_debt, m_debt);
    check_val("debt_overflow", debt_overflow, m_ovf);
    check_val("acc_ready", acc_ready, m_idle() && (m_debt != LIM));
  endtask

  task automatic advance(input bit av, input bit rw, input int bk, input bit ack);
    int  old_debt;
    bit  tick, dec;
    old_debt = m_debt;
    tick = ((m_cyc + 1) % RI) == 0;
    dec  = m_req && m_is_ref && ack;
    if (tick && old_debt == LIM) m_ovf = 1;
    if (tick && !dec && old_debt < LIM) m_debt = m_debt + 1;
    else if (dec && !tick) m_debt = m_debt - 1;
    if (tick && dec) coincide++;
    if (m_idle()) begin
      if (old_debt == LIM || (!av && old_debt > 0)) begin
        m_req = 1; m_is_ref = 1; m_cmd = 3; m_bank = 0;
      end else if (av) begin
        m_req = 1; m_is_ref = 0; m_cmd = rw ? 2 : 1; m_bank = bk;
      end
    end else if (m_req) begin
      if (ack) begin
        m_req = 0; m_wait_low = 1; txns++;
        $display("TXN %0d t=%0t cmd=%0d bank=%0d debt_after=%0d", txns, $time, m_cmd, m_bank, m_debt);
      end
    end else if (m_wait_low) begin
      if (!ack) begin
        m_wait_low = 0;
        if (m_is_ref) m_rfc_left = TRFC;
      end
    end else begin
      m_rfc_left = m_rfc_left - 1;
    end
    m_cyc++;
  endtask

  // Called at a falling edge: check, drive the next inputs, advance the model, move one cycle.
  task automatic step(input bit av, input bit rw, input int bk);
    compare_outputs();
    acc_valid   = av;
    acc_rw      = rw;
    acc_bank_id = bk[BW-1:0];
    advance(av, rw, bk % NB, cmd_ack);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check_val("rst_cmd_req", cmd_req, 0);
    check_val("rst_debt", refresh_debt, 0);
    check_val("rst_overflow", debt_overflow, 0);
    check_val("rst_flag", refresh_flag, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    int n;
    rst = 1'b1; acc_valid = 1'b0; acc_rw = 1'b0; acc_bank_id = '0; ack_block = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;

    step(1, 1, 5);
    repeat (40) step(0, 0, 0);
    repeat (80) step(1, 1'($urandom % 2), int'($urandom % NB));

    ack_block = 1'b1;
    repeat (70) step(1, 1'($urandom % 2), int'($urandom % NB));
    ack_block = 1'b0;
    repeat (40) step(0, 0, 0);

    do_reset();
    n = 0;
    while (!(m_req && m_is_ref) && n < 200) begin
      step(0, 0, 0);
      n++;
    end
    check_val("ref_req_seen", (cmd_req && cmd == 2'b11), 1);
    do_reset();
    step(1, 0, 3);
    repeat (20) step(0, 0, 0);

    for (int seg = 0; seg < 8; seg++) begin
      do_reset();
      for (int i = 0; i < 600; i++) begin
        if (seg == 5) ack_block = (i > 100 && i < 180);
        step($urandom_range(0, 99) < 55, 1'($urandom % 2), int'($urandom % NB));
      end
      ack_block = 1'b0;
    end

    $display("INFO transactions %0d tick_on_refresh_ack %0d", txns, coincide);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
